// File: rtl/ic_data_refill_wr.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ic_data_refill_wr : I-cache data RAM refill writer, critical-word-first |
// |   ic_data_ecc_encoder : 8-bit SEC-DED check bits over {data, addr}      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+

// ecc[5:0] Hamming checks over data bits placed at non-power-of-2 positions
// 1..49 (bit 0 of {wdata, addr} first); ecc[6] address parity; ecc[7] overall.
module ic_data_ecc_encoder (
   input  logic [42:0] data,
   output logic [7:0]  ecc
);
   always_comb begin
      logic [5:0] chk;
      int         k;
      chk = '0;
      k   = 0;
      for (int p = 1; p < 50; p++) begin
         if ((p & (p - 1)) != 0) begin
            for (int b = 0; b < 6; b++) begin
               if (p[b]) chk[b] = chk[b] ^ data[k];
            end
            k = k + 1;
         end
      end
      ecc[5:0] = chk;
      ecc[6]   = ^data[10:0];
      ecc[7]   = (^data) ^ (^chk) ^ (^data[10:0]);
   end
endmodule

module ic_data_refill_wr #(
   parameter int LINE_WORDS = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_a,
   input  logic                          refill_start,
   input  logic [10:0]                   refill_line_addr,
   input  logic [$clog2(LINE_WORDS)-1:0] refill_first_word,
   input  logic                          refill_valid,
   output logic                          refill_ready,
   input  logic [31:0]                   refill_data,
   input  logic                          refill_err,
   output logic                          ram_we,
   input  logic                          ram_gnt,
   output logic [10:0]                   ram_addr,
   output logic [31:0]                   ram_wdata,
   output logic [7:0]                    ram_wecc,
   output logic                          refill_busy,
   output logic                          refill_done,
   output logic                          refill_abort
);
   localparam int OW   = $clog2(LINE_WORDS);
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_DRAIN = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic [10:OW]      r_line_hi;
   logic [OW-1:0]     r_first;
   logic [OW-1:0]     r_beat_cnt;
   logic              r_err;
   logic              r_busy;
   logic              r_done;
   logic              r_abort;

   logic [42:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CNTW-1:0]   r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_last;
   logic              w_push;
   logic              w_flush;
   logic              w_pop;
   logic [CNTW-1:0]   w_count_next;
   logic [OW-1:0]     w_offset;
   logic [42:0]       w_push_word;
   logic [42:0]       w_head;
   logic              w_unused;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Line base low bits are replaced by the wrapped offset, never added to.
   assign w_unused = ^refill_line_addr[OW-1:0];

   assign w_full   = (r_count == CNTW'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);

   // Handshake and write request decode from registers only (no path from ram_gnt).
   always_comb begin
      refill_ready = 1'b0;
      case (r_state)
         S_FILL:  refill_ready = !w_full;
         S_FLUSH: refill_ready = 1'b1;
         default: refill_ready = 1'b0;
      endcase
   end

   assign ram_we       = ((r_state == S_FILL) || (r_state == S_DRAIN)) && !w_empty;

   assign w_accept     = refill_valid & refill_ready;
   assign w_last       = (r_beat_cnt == OW'(LINE_WORDS - 1));
   assign w_push       = (r_state == S_FILL) & w_accept & !refill_err;
   assign w_flush      = (r_state == S_FILL) & w_accept & refill_err;
   assign w_pop        = ram_we & ram_gnt;
   assign w_count_next = w_flush ? '0 : (r_count + CNTW'(w_push) - CNTW'(w_pop));

   assign w_offset     = r_first + r_beat_cnt;
   assign w_push_word  = {refill_data, r_line_hi, w_offset};

   assign w_head       = r_mem[r_rd_ptr];
   assign ram_addr     = w_head[10:0];
   assign ram_wdata    = w_head[42:11];

   ic_data_ecc_encoder u_ecc (
      .data (w_head),
      .ecc  (ram_wecc)
   );

   assign refill_busy  = r_busy;
   assign refill_done  = r_done;
   assign refill_abort = r_abort;

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= w_push_word;
               r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         r_state    <= S_IDLE;
         r_line_hi  <= '0;
         r_first    <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (refill_start) begin
                  r_line_hi  <= refill_line_addr[10:OW];
                  r_first    <= refill_first_word;
                  r_beat_cnt <= '0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + OW'(1);
                  if (refill_err) begin
                     r_err <= 1'b1;
                     if (w_last) begin
                        r_abort <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_state <= S_FLUSH;
                     end
                  end else if (w_last) begin
                     if (w_count_next == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_state <= S_DRAIN;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + OW'(1);
                  if (w_last) begin
                     r_abort <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DRAIN: begin
               if (w_count_next == '0) begin
                  r_done  <= !r_err;
                  r_abort <= r_err;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ic_data_refill_wr.sv
`default_nettype none
// Bench for ic_data_refill_wr: directed and random line refills compared
// against a queue-based model of the expected RAM writes and ECC.
module tb_ic_data_refill_wr;
   localparam int LW = 8;

   logic        clk;
   logic        rst_a;
   logic        refill_start;
   logic [10:0] refill_line_addr;
   logic [2:0]  refill_first_word;
   logic        refill_valid;
   logic        refill_ready;
   logic [31:0] refill_data;
   logic        refill_err;
   logic        ram_we;
   logic        ram_gnt;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [7:0]  ram_wecc;
   logic        refill_busy;
   logic        refill_done;
   logic        refill_abort;

   ic_data_refill_wr #(.LINE_WORDS(LW), .FIFO_DEPTH(2)) dut (
      .clk               (clk),
      .rst_a             (rst_a),
      .refill_start      (refill_start),
      .refill_line_addr  (refill_line_addr),
      .refill_first_word (refill_first_word),
      .refill_valid      (refill_valid),
      .refill_ready      (refill_ready),
      .refill_data       (refill_data),
      .refill_err        (refill_err),
      .ram_we            (ram_we),
      .ram_gnt           (ram_gnt),
      .ram_addr          (ram_addr),
      .ram_wdata         (ram_wdata),
      .ram_wecc          (ram_wecc),
      .refill_busy       (refill_busy),
      .refill_done       (refill_done),
      .refill_abort      (refill_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [10:0] a;
      logic [31:0] d;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] beat_data [LW];
   wr_t         obs_q [$];
   wr_t         exp_q [$];
   int          done_cyc, abort_cyc, busy_fall, n_done, n_abort;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hamming SEC-DED: the six low check bits are the XOR of the positions of
   // every set data bit, data bits skipping power-of-two positions.
   function automatic logic [7:0] ecc_model(input logic [31:0] d, input logic [10:0] a);
      logic [42:0] v;
      logic [5:0]  syn;
      logic [7:0]  e;
      int          p;
      v   = {d, a};
      syn = '0;
      p   = 0;
      for (int i = 0; i < 43; i++) begin
         p++;
         while ((p & (p - 1)) == 0) p++;
         if (v[i]) syn = syn ^ 6'(p);
      end
      e[5:0] = syn;
      e[6]   = ^a;
      e[7]   = ^{v, e[6:0]};
      return e;
   endfunction

   // gnt_mode: 0 = always granted, 1 = withheld for cycles 0..5, 2 = random.
   task automatic run_line(input int base, input int fw, input int err_beat,
                           input int gnt_mode, input bit rand_valid,
                           input int restart_at, input int rst_at);
      int          beat, cyc;
      bit          prev_stall;
      logic [10:0] pa;
      logic [31:0] pd;
      logic [7:0]  pe;
      wr_t         w;
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < LW; i++) begin
         if (err_beat < 0 || i < err_beat) begin
            w.a = 11'((base & ~(LW - 1)) | ((fw + i) % LW));
            w.d = beat_data[i];
            exp_q.push_back(w);
         end
      end
      beat = 0; cyc = 0; prev_stall = 0;
      done_cyc = -1; abort_cyc = -1; busy_fall = -1; n_done = 0; n_abort = 0;
      pa = '0; pd = '0; pe = '0;
      while (cyc < 300) begin
         refill_start      = (cyc == 0) || (cyc == restart_at);
         refill_line_addr  = (cyc == restart_at) ? ~11'(base) : 11'(base);
         refill_first_word = 3'(fw);
         refill_valid      = (beat < LW) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
         refill_data       = (beat < LW) ? beat_data[beat] : $urandom;
         refill_err        = (beat == err_beat);
         ram_gnt           = (gnt_mode == 0) ? 1'b1 :
                             (gnt_mode == 1) ? (cyc >= 6) : ($urandom_range(0, 1) == 1);
         if (cyc == rst_at) begin
            chk("pre_reset_draining", {ram_we, refill_busy, refill_ready}, 3'b110);
            rst_a = 1'b0;
            #1;
            chk("reset_outputs_zero",
                {refill_ready, ram_we, ram_addr, ram_wdata, ram_wecc, refill_busy, refill_done, refill_abort}, '0);
            return;
         end
         #7;
         if (prev_stall) begin
            chk("stall_addr", ram_addr, pa);
            chk("stall_wdata", ram_wdata, pd);
            chk("stall_wecc", ram_wecc, pe);
         end
         prev_stall = ram_we && !ram_gnt;
         pa = ram_addr; pd = ram_wdata; pe = ram_wecc;
         if (ram_we && ram_gnt) begin
            w.a = ram_addr;
            w.d = ram_wdata;
            obs_q.push_back(w);
            chk("wecc_vs_model", ram_wecc, ecc_model(ram_wdata, ram_addr));
         end
         if (err_beat >= 0 && beat > err_beat && beat < LW) begin
            chk("flush_ready", refill_ready, 1'b1);
            chk("flush_no_we", ram_we, 1'b0);
         end
         if (refill_valid && refill_ready) beat++;
         if (gnt_mode == 1 && cyc == 5) begin
            chk("stall_accepts", beat, 2);
            chk("stall_ready_low", refill_ready, 1'b0);
         end
         if (refill_done) begin n_done++; done_cyc = cyc; end
         if (refill_abort) begin n_abort++; abort_cyc = cyc; end
         if (!refill_busy && cyc > 0 && busy_fall < 0) busy_fall = cyc;
         @(posedge clk); #1;
         cyc++;
         if (busy_fall >= 0 && cyc > busy_fall + 2) break;
      end
      refill_start = 1'b0;
      refill_valid = 1'b0;
      refill_err   = 1'b0;
      chk("line_timeout", (cyc >= 300), 1'b0);
      chk("write_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk("write_addr", obs_q[i].a, exp_q[i].a);
         chk("write_data", obs_q[i].d, exp_q[i].d);
      end
      chk("done_count", n_done, (err_beat < 0) ? 1 : 0);
      chk("abort_count", n_abort, (err_beat < 0) ? 0 : 1);
   endtask

   initial begin
      rst_a = 1'b0; refill_start = 1'b0; refill_line_addr = '0; refill_first_word = '0;
      refill_valid = 1'b0; refill_data = '0; refill_err = 1'b0; ram_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state",
          {refill_ready, ram_we, ram_addr, ram_wdata, ram_wecc, refill_busy, refill_done, refill_abort}, '0);
      rst_a = 1'b1;
      @(posedge clk); #1;

      // Back-to-back line, gnt = 1, fixed data
      for (int i = 0; i < LW; i++) beat_data[i] = 32'hA0 + i;
      run_line(11'h1A8, 0, -1, 0, 0, -1, -1);
      chk("b2b_done_cycle", done_cyc, LW + 2);
      chk("b2b_first_addr", obs_q.size() > 0 ? obs_q[0].a : 11'h0, 11'h1A8);

      // Critical-word wrap at top of address space
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h7F8, 5, -1, 0, 0, -1, -1);
      chk("wrap_first_addr", obs_q.size() > 0 ? obs_q[0].a : 11'h0, 11'h7FD);
      chk("wrap_fourth_addr", obs_q.size() > 3 ? obs_q[3].a : 11'h0, 11'h7F8);

      // Arbiter stall for the first 6 cycles
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h230, 2, -1, 1, 0, -1, -1);

      // Bus error on beat 3
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h455, 1, 3, 0, 0, -1, -1);

      // refill_start during FILL must not move the line base
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h110, 6, -1, 0, 0, 3, -1);

      // Error on the last beat
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h3C0, 0, LW - 1, 0, 0, -1, -1);
      chk("last_err_abort_cycle", abort_cyc, LW + 1);
      chk("last_err_busy_fall", busy_fall, LW + 2);

      // Reset mid-DRAIN, then no writes until a new start
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h088, 0, -1, 0, 0, -1, LW + 1);
      refill_start = 1'b0;
      refill_valid = 1'b1;
      ram_gnt      = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #7;
         chk("post_reset_no_we", {ram_we, refill_busy}, 2'b00);
         @(posedge clk); #1;
      end
      refill_valid = 1'b0;
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      run_line(11'h088, 4, -1, 0, 0, -1, -1);
      chk("post_reset_done_cycle", done_cyc, LW + 2);

      // Random lines: random valid gaps and grant pattern, occasional errors
      for (int t = 0; t < 12; t++) begin
         int eb;
         for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
         eb = ((t % 3) == 2) ? int'($urandom_range(0, LW - 1)) : -1;
         run_line(int'($urandom_range(0, 2047)), int'($urandom_range(0, LW - 1)), eb,
                  (eb < 0) ? 2 : 0, 1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
